// File: rtl/if_stage_if.sv
// Bundle of if_stage signals: redirects, imem fetch port and IF/ID outputs.
// master = fetch stage, slave = hazard/decode/imem side.
interface if_stage_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    modport master (
        input  stall, br_taken, br_target, jmp, jmp_target, imem_inst,
        output imem_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_cnt, stall_cnt
    );

    modport slave (
        output stall, br_taken, br_target, jmp, jmp_target, imem_inst,
        input  imem_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Define IF_STAGE_PERF_CNT_EN to build the saturating fetch/stall counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    if_stage_if.master  bus
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc_nxt;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        redirect;

    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    assign pc4      = pc + 32'd4;
    assign br_tgt   = bus.br_target  & 32'hFFFF_FFFC;
    assign jmp_tgt  = bus.jmp_target & 32'hFFFF_FFFC;
    assign redirect = bus.br_taken | bus.jmp;

    // Branch is older than the jump, so it wins; any redirect beats stall.
    always_comb begin
        pc_nxt = pc4;
        if (bus.br_taken)
            pc_nxt = br_tgt;
        else if (bus.jmp)
            pc_nxt = jmp_tgt;
        else if (bus.stall)
            pc_nxt = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_inst  <= NOP_INST;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            ifid_inst  <= NOP_INST;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (!bus.stall) begin
            ifid_inst  <= bus.imem_inst;
            ifid_pc4   <= pc4;
            ifid_valid <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.ifid_inst  = ifid_inst;
    assign bus.ifid_pc4   = ifid_pc4;
    assign bus.ifid_valid = ifid_valid;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_q;
    logic [31:0] stall_q;
    logic        fetch_ev;
    logic        stall_ev;

    assign fetch_ev = !redirect && !bus.stall;
    assign stall_ev = bus.stall && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= 32'h0;
            stall_q <= 32'h0;
        end else begin
            if (fetch_ev && (fetch_q != 32'hFFFF_FFFF))
                fetch_q <= fetch_q + 32'd1;
            if (stall_ev && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_q;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.fetch_cnt = 32'h0;
    assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Table-driven bench for if_stage with an expected-value queue and
// hand sequences for async reset; counters checked per IF_STAGE_PERF_CNT_EN.
module tb_if_stage;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: addr 0 holds a known word, others tag the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h2002_0005;
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb bus.imem_inst = mem(bus.imem_addr);

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    vec_t        vecs[17];
    exp_t        sb[$];
    logic [31:0] fcnt_m;
    logic [31:0] scnt_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        bus.stall      = s;
        bus.br_taken   = b;
        bus.br_target  = bt;
        bus.jmp        = j;
        bus.jmp_target = jt;
    endtask

    task automatic check_cnt(input string tag);
`ifdef IF_STAGE_PERF_CNT_EN
        chk({tag, "_fetch_cnt"}, bus.fetch_cnt, fcnt_m);
        chk({tag, "_stall_cnt"}, bus.stall_cnt, scnt_m);
`else
        chk({tag, "_fetch_cnt"}, bus.fetch_cnt, 32'h0);
        chk({tag, "_stall_cnt"}, bus.stall_cnt, 32'h0);
`endif
    endtask

    // Drive one row, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        string tag;
        drive(v.stall, v.br, v.br_t, v.jmp, v.jmp_t);
        if (!v.br && !v.jmp && !v.stall) fcnt_m = fcnt_m + 1;
        if (v.stall && !v.br && !v.jmp)  scnt_m = scnt_m + 1;
        e.addr  = v.e_addr;
        e.inst  = v.e_inst;
        e.pc4   = v.e_pc4;
        e.valid = v.e_valid;
        e.fcnt  = fcnt_m;
        e.scnt  = scnt_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        tag = $sformatf("row%0d", idx);
        chk({tag, "_imem_addr"}, bus.imem_addr, got.addr);
        chk({tag, "_ifid_inst"}, bus.ifid_inst, got.inst);
        chk({tag, "_ifid_pc4"},  bus.ifid_pc4,  got.pc4);
        chk({tag, "_ifid_valid"}, {31'h0, bus.ifid_valid}, {31'h0, got.valid});
`ifdef IF_STAGE_PERF_CNT_EN
        chk({tag, "_fetch_cnt"}, bus.fetch_cnt, got.fcnt);
        chk({tag, "_stall_cnt"}, bus.stall_cnt, got.scnt);
`else
        chk({tag, "_fetch_cnt"}, bus.fetch_cnt, 32'h0);
        chk({tag, "_stall_cnt"}, bus.stall_cnt, 32'h0);
`endif
    endtask

    initial begin
        //          stall br  br_t          jmp jmp_t         addr          inst          pc4           v
        vecs[0]  = '{0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h2002_0005, 32'h4,        1};
        vecs[1]  = '{0, 0, 32'h0,        0, 32'h0,        32'h8,        32'hC0DE_0004, 32'h8,        1};
        vecs[2]  = '{0, 0, 32'h0,        0, 32'h0,        32'hC,        32'hC0DE_0008, 32'hC,        1};
        vecs[3]  = '{1, 0, 32'h0,        0, 32'h0,        32'hC,        32'hC0DE_0008, 32'hC,        1};
        vecs[4]  = '{1, 0, 32'h0,        0, 32'h0,        32'hC,        32'hC0DE_0008, 32'hC,        1};
        vecs[5]  = '{0, 0, 32'h0,        0, 32'h0,        32'h10,       32'hC0DE_000C, 32'h10,       1};
        vecs[6]  = '{1, 1, 32'h46,       0, 32'h0,        32'h44,       32'h0,         32'h0,        0};
        vecs[7]  = '{0, 0, 32'h0,        0, 32'h0,        32'h48,       32'hC0DE_0044, 32'h48,       1};
        vecs[8]  = '{0, 1, 32'h40,       1, 32'h80,       32'h40,       32'h0,         32'h0,        0};
        vecs[9]  = '{0, 0, 32'h0,        1, 32'h80,       32'h80,       32'h0,         32'h0,        0};
        vecs[10] = '{0, 0, 32'h0,        1, 32'h83,       32'h80,       32'h0,         32'h0,        0};
        vecs[11] = '{1, 0, 32'h0,        1, 32'h123,      32'h120,      32'h0,         32'h0,        0};
        vecs[12] = '{0, 0, 32'h0,        0, 32'h0,        32'h124,      32'hC0DE_0120, 32'h124,      1};
        vecs[13] = '{0, 0, 32'h0,        1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,       32'h0,        0};
        vecs[14] = '{0, 0, 32'h0,        0, 32'h0,        32'h0,        32'hC0DE_FFFC, 32'h0,        1};
        vecs[15] = '{1, 0, 32'h0,        0, 32'h0,        32'h0,        32'hC0DE_FFFC, 32'h0,        1};
        vecs[16] = '{0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h2002_0005, 32'h4,        1};

        tests  = 0;
        fails  = 0;
        fcnt_m = 32'h0;
        scnt_m = 32'h0;
        drive(0, 0, 32'h0, 0, 32'h0);
        rst_n = 1'b0;
        #12;
        chk("rst_imem_addr",  bus.imem_addr, 32'h0);
        chk("rst_ifid_inst",  bus.ifid_inst, 32'h0);
        chk("rst_ifid_pc4",   bus.ifid_pc4,  32'h0);
        chk("rst_ifid_valid", {31'h0, bus.ifid_valid}, 32'h0);
        check_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            step(vecs[i], i);

        // Walk PC from 4 to 0x20, then pulse reset between edges.
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 32'h0, 0, 32'h0);
            fcnt_m = fcnt_m + 1;
            @(posedge clk);
            #1;
        end
        chk("pre_rst_imem_addr", bus.imem_addr, 32'h20);
        chk("pre_rst_ifid_pc4",  bus.ifid_pc4,  32'h20);
        check_cnt("pre_rst");

        // Pending jump and stall during reset must be discarded.
        drive(1, 0, 32'h0, 1, 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        fcnt_m = 32'h0;
        scnt_m = 32'h0;
        chk("async_rst_imem_addr",  bus.imem_addr, 32'h0);
        chk("async_rst_ifid_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("async_rst_ifid_inst",  bus.ifid_inst, 32'h0);
        check_cnt("async_rst");
        @(posedge clk);
        #1;
        chk("held_rst_imem_addr", bus.imem_addr, 32'h0);
        chk("held_rst_ifid_valid", {31'h0, bus.ifid_valid}, 32'h0);
        drive(0, 0, 32'h0, 0, 32'h0);
        rst_n = 1'b1;
        fcnt_m = fcnt_m + 1;
        @(posedge clk);
        #1;
        chk("post_rst_imem_addr",  bus.imem_addr, 32'h4);
        chk("post_rst_ifid_inst",  bus.ifid_inst, 32'h2002_0005);
        chk("post_rst_ifid_pc4",   bus.ifid_pc4,  32'h4);
        chk("post_rst_ifid_valid", {31'h0, bus.ifid_valid}, 32'h1);
        check_cnt("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INST, default 32'h0000_0000, the instruction word inserted into IF/ID on flush or reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard-unit hold of PC and IF/ID.
REQ-006 br_taken  input  1  branch resolved taken (older instruction).
REQ-007 br_target  input  32  branch redirect address.
REQ-008 jmp  input  1  jump decoded (younger than branch).
REQ-009 jmp_target  input  32  jump redirect address.
REQ-010 imem_addr  output  32  fetch address to instruction memory.
REQ-011 imem_inst  input  32  instruction word returned combinationally for imem_addr.
REQ-012 ifid_inst  output  32  registered instruction to decode.
REQ-013 ifid_pc4  output  32  registered PC+4 of ifid_inst.
REQ-014 ifid_valid  output  1  ifid_inst is a real fetched instruction.
REQ-015 fetch_cnt  output  32  valid instructions delivered (Configuration).
REQ-016 stall_cnt  output  32  cycles with stall asserted (Configuration).

Function
REQ-017 imem_addr SHALL equal the PC register combinationally; zero added latency.
REQ-018 Next-PC priority SHALL be: br_taken -> br_target; else jmp -> jmp_target; else stall -> hold PC; else PC+4.
REQ-019 Redirect targets SHALL have bits [1:0] forced to 2'b00 before loading PC.
REQ-020 PC+4 SHALL be computed modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000), no flag.
REQ-021 br_taken or jmp SHALL override stall in the same cycle.
REQ-022 On br_taken or jmp, IF/ID SHALL load ifid_inst=NOP_INST, ifid_pc4=32'h0, ifid_valid=0 at the next edge (one-bubble squash).
REQ-023 Else on stall, IF/ID SHALL hold all three fields unchanged.
REQ-024 Else IF/ID SHALL load imem_inst, PC+4 and ifid_valid=1.
REQ-025 Fetch-to-decode latency SHALL be exactly one clock edge after imem_addr presents the PC.
REQ-026 A redirect asserted for N consecutive cycles SHALL load the target each cycle and keep IF/ID flushed for all N.

Reset
REQ-027 rst_n low SHALL immediately (no clock) set PC=RESET_PC, ifid_inst=NOP_INST, ifid_pc4=0, ifid_valid=0, fetch_cnt=0, stall_cnt=0.
REQ-028 Reset mid-operation SHALL discard pending redirect/stall; first edge after release SHALL fetch RESET_PC into IF/ID unless stalled or redirected.

Configuration
REQ-029 Macro IF_STAGE_PERF_CNT_EN SHALL gate the performance counters.
REQ-030 With it defined: fetch_cnt SHALL increment on each edge loading ifid_valid=1; stall_cnt SHALL increment each edge with stall=1 and no redirect; both saturate at 32'hFFFF_FFFF.
REQ-031 Without it: fetch_cnt and stall_cnt SHALL be constant 32'h0; ports remain present; no counter flops.

Verification
REQ-032 Reset release, imem returns 32'h20020005 at addr 0 -> after 1st edge ifid_inst=32'h20020005, ifid_pc4=4, ifid_valid=1, imem_addr=4.
REQ-033 stall=1 for 2 cycles at PC=12 -> imem_addr stays 12, IF/ID unchanged, stall_cnt +2 (macro on), fetch_cnt unchanged.
REQ-034 br_taken=1, br_target=32'h46, stall=1 simultaneously -> next imem_addr=32'h44, ifid_valid=0, ifid_inst=NOP_INST.
REQ-035 br_taken=1 (target 32'h40) and jmp=1 (target 32'h80) same cycle -> imem_addr=32'h40.
REQ-036 PC=32'hFFFF_FFFC, no stall/redirect -> imem_addr=32'h0, ifid_pc4=32'h0, ifid_valid=1.
REQ-037 rst_n pulsed low between edges at PC=32'h20 -> PC=RESET_PC and ifid_valid=0 immediately, before next edge; with macro off, counters read 0 throughout.
